// File: rtl/csa_resolve_seq_if.sv
// Operand/result handshake bundle for csa_resolve_seq: one valid/ready pair
// carries the carry-save operands in, the other carries the binary result out.
interface csa_resolve_seq_if #(
  parameter int unsigned W = 18
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   s_in;
  logic [W:0]     c_in;
  logic           out_valid;
  logic           out_ready;
  logic [W+1:0]   sum_out;

  modport master (
    output in_valid, s_in, c_in, out_ready,
    input  in_ready, out_valid, sum_out
  );

  modport slave (
    input  in_valid, s_in, c_in, out_ready,
    output in_ready, out_valid, sum_out
  );
endinterface

// File: rtl/csa_resolve_seq.sv
// Resolves a carry-save (sum, shifted carry) pair to binary with a segmented
// carry-propagate adder, SEG result bits per clock over NSEG busy cycles.
module csa_resolve_seq #(
  parameter int unsigned W   = 18,
  parameter int unsigned SEG = 6
) (
  input  logic             clk,
  input  logic             rst,
  csa_resolve_seq_if.slave bus
);
  localparam int unsigned WO   = W + 2;
  localparam int unsigned NSEG = (WO + SEG - 1) / SEG;
  localparam int unsigned CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int unsigned SW   = SEG + 1;
  localparam logic [WO-1:0] SEG_MASK = WO'({SEG{1'b1}});

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [WO-1:0]   op_a;
  logic [WO-1:0]   op_b;
  logic [WO-1:0]   res;
  logic [WO-1:0]   res_next;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [31:0]     sh;
  logic [SEG-1:0]  seg_a;
  logic [SEG-1:0]  seg_b;
  logic [SEG:0]    seg_sum;

  // Bits shifted past WO vanish, so the partial top segment needs no special case.
  always_comb begin
    sh       = 32'(cnt) * SEG;
    seg_a    = SEG'(op_a >> sh);
    seg_b    = SEG'(op_b >> sh);
    seg_sum  = {1'b0, seg_a} + {1'b0, seg_b} + SW'(carry);
    res_next = (res & ~(SEG_MASK << sh)) | (WO'(seg_sum[SEG-1:0]) << sh);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= WO'(bus.s_in);
            op_b  <= WO'(bus.c_in);
            carry <= 1'b0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          res   <= res_next;
          carry <= seg_sum[SEG];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NSEG - 1)) state <= DONE;
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.sum_out   = res;
endmodule

// File: tb/tb_csa_resolve_seq.sv
// Directed bench for csa_resolve_seq at W=18, SEG=6: vector table plus
// backpressure, back-to-back and mid-operation reset sequences.
module tb_csa_resolve_seq;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  csa_resolve_seq_if #(.W(18)) bus ();

  csa_resolve_seq #(.W(18), .SEG(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] s;
    logic [18:0] c;
    logic [19:0] e;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid first shows.
  task automatic run_txn(input logic [17:0] s, input logic [18:0] c,
                         input logic [19:0] e, input string name);
    int lat;
    lat = 0;
    chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.s_in     = s;
    bus.c_in     = c;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.s_in     = ~s;
    bus.c_in     = ~c;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) lat = n;
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_sum"}, 32'(bus.sum_out), 32'(e));
  endtask

  initial begin
    int hits;
    int hit_cyc[4];
    logic [19:0] hit_sum[4];

    total = 0;
    bad   = 0;
    vecs[0] = '{18'h3FFFF, 19'h7FFFE, 20'hBFFFD};
    vecs[1] = '{18'h3FFFF, 19'h00001, 20'h40000};
    vecs[2] = '{18'h00000, 19'h00000, 20'h00000};
    vecs[3] = '{18'h12345, 19'h0ABCE, 20'h1CF13};
    vecs[4] = '{18'h2AAAA, 19'h55555, 20'h7FFFF};
    vecs[5] = '{18'h3FFFF, 19'h7FFFF, 20'hBFFFE};
    vecs[6] = '{18'h20000, 19'h40000, 20'h60000};
    vecs[7] = '{18'h00010, 19'h00020, 20'h00030};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.s_in      = '0;
    bus.c_in      = '0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_sum", 32'(bus.sum_out), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].s, vecs[i].c, vecs[i].e, $sformatf("vec%0d", i));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid_one_cycle", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("vec%0d_idle_ready", i), 32'(bus.in_ready), 32'd1);
      chk($sformatf("vec%0d_sum_retained", i), 32'(bus.sum_out), 32'(vecs[i].e));
    end

    // Backpressure: result held, new operand waits until DONE is left.
    bus.out_ready = 1'b0;
    run_txn(18'h00100, 19'h00200, 20'h00300, "bp_first");
    bus.in_valid = 1'b1;
    bus.s_in     = 18'h00005;
    bus.c_in     = 19'h00000;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_hold_sum%0d", i), 32'(bus.sum_out), 32'h00300);
      chk($sformatf("bp_hold_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    run_txn(18'h00005, 19'h00000, 20'h00005, "bp_second");
    @(posedge clk);
    @(negedge clk);

    // Back-to-back with in_valid held: second pair is presented while BUSY.
    hits = 0;
    bus.in_valid = 1'b1;
    bus.s_in     = 18'h12345;
    bus.c_in     = 19'h0ABCE;
    @(posedge clk);
    @(negedge clk);
    bus.s_in = 18'h00010;
    bus.c_in = 19'h00020;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid && hits < 4) begin
        hit_cyc[hits] = cyc;
        hit_sum[hits] = bus.sum_out;
        hits++;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_count", 32'(hits), 32'd2);
    if (hits >= 2) begin
      chk("b2b_first_cycle", 32'(hit_cyc[0]), 32'd4);
      chk("b2b_first_sum", 32'(hit_sum[0]), 32'h1CF13);
      chk("b2b_second_cycle", 32'(hit_cyc[1]), 32'd10);
      chk("b2b_second_sum", 32'(hit_sum[1]), 32'h00030);
    end
    @(posedge clk);
    @(negedge clk);

    // Reset during BUSY segment k=2 aborts the transaction.
    bus.in_valid = 1'b1;
    bus.s_in     = 18'h3FFFF;
    bus.c_in     = 19'h7FFFE;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy_sum", 32'(bus.sum_out), 32'd0);
    chk("rst_busy_in_ready", 32'(bus.in_ready), 32'd0);
    rst  = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) hits++;
    end
    chk("rst_busy_no_valid", 32'(hits), 32'd0);
    run_txn(18'h00001, 19'h00002, 20'h00003, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
